// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF       = 18;
    localparam int unsigned DEFAULT_DIV_DEF = 4999;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_STROBE = 1'b1;

    // Width of a channel index; a single channel still needs one select bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration write channel of the multi-channel clock divider.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow divisor and mode,
// pending-update flag and the registered clk_out/tick outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] shadow_div;
    logic             mode_act;
    logic             shadow_mode;

    logic terminal_c;
    logic apply_c;
    logic mode_flip_c;

    // Period boundary detection and the update-apply decision.
    always_comb begin
        terminal_c  = en && (cnt == div_act);
        apply_c     = pending && (terminal_c || !en);
        mode_flip_c = apply_c && (shadow_mode != mode_act);
    end

    // Period counter; an apply always coincides with a restart from zero.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || terminal_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow capture on accept, promotion to active at the period boundary.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_act     <= CNT_W'(DEFAULT_DIV);
            mode_act    <= MODE_TOGGLE;
            shadow_div  <= '0;
            shadow_mode <= MODE_TOGGLE;
            pending     <= 1'b0;
        end else if (apply_c) begin
            div_act     <= shadow_div;
            mode_act    <= shadow_mode;
            pending     <= 1'b0;
        end else if (wr) begin
            shadow_div  <= wr_div;
            shadow_mode <= wr_mode;
            pending     <= 1'b1;
        end
    end

    // Output generation; a mode switch parks both outputs low.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!en || mode_flip_c) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (mode_act == MODE_STROBE) begin
            clk_out <= 1'b0;
            tick    <= terminal_c;
        end else begin
            clk_out <= clk_out ^ terminal_c;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, ready mux,
// per-channel dividers and a fixed clk_in/2 output.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic               clk_in,
    input  logic               reset,
    clk_div_multi_if.slave     cfg,
    input  logic [NUM_CH-1:0]  ch_en,
    output logic [NUM_CH-1:0]  clk_out,
    output logic [NUM_CH-1:0]  tick,
    output logic               clk_half
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_sel_c;
    logic              ready_c;

    // Ready follows the addressed channel; an unmapped index always accepts.
    always_comb begin
        ready_c = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                ready_c = ~pending[i];
            end
        end
    end

    assign cfg.cfg_ready = ready_c;

    // One-hot write strobe to the addressed channel on handshake.
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel_c[i] = cfg.cfg_valid && ready_c && (cfg.cfg_ch == CH_W'(i));
        end
    end

    // Free-running clk_in/2.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_half <= 1'b0;
        end else begin
            clk_half <= ~clk_half;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (ch_en[g]),
            .wr      (wr_sel_c[g]),
            .wr_div  (cfg.cfg_div),
            .wr_mode (cfg.cfg_mode),
            .pending (pending[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a cycle-indexed reference model
// predicts outputs from elapsed time modulo the period.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned CNT_W   = CNT_W_DEF;
    localparam int unsigned DEF_DIV = 3;
    localparam int unsigned CH_W    = ch_idx_w(NUM_CH);

    logic              clk_in = 1'b0;
    logic              reset  = 1'b1;
    logic [NUM_CH-1:0] ch_en  = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic              clk_half;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg ();

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .cfg      (cfg),
        .ch_en    (ch_en),
        .clk_out  (clk_out),
        .tick     (tick),
        .clk_half (clk_half)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NUM_CH-1:0] clk_out;
        logic [NUM_CH-1:0] tick;
        logic              half;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: divisor/mode as seen by the outputs, the
    // queued update, and the cycle at which the current counting run began.
    int unsigned       m_d[NUM_CH];
    int unsigned       m_sd[NUM_CH];
    bit                m_mode[NUM_CH];
    bit                m_smode[NUM_CH];
    bit                m_pend[NUM_CH];
    longint            m_tseg[NUM_CH];
    bit [NUM_CH-1:0]   m_lvl;
    bit [NUM_CH-1:0]   m_tick;
    longint            m_n;
    bit                m_half;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_d[i]     = DEF_DIV;
            m_sd[i]    = 0;
            m_mode[i]  = 1'b0;
            m_smode[i] = 1'b0;
            m_pend[i]  = 1'b0;
            m_tseg[i]  = 0;
        end
        m_lvl  = '0;
        m_tick = '0;
        m_n    = 0;
        m_half = 1'b0;
    endfunction

    // One clk_in edge of the reference: a boundary is any cycle whose offset
    // into the current run is D modulo the period D+1.
    function automatic void model_step();
        bit          acc;
        int unsigned ach;
        ach = int'(cfg.cfg_ch);
        acc = cfg.cfg_valid && (ach < NUM_CH) && !m_pend[ach];
        for (int i = 0; i < NUM_CH; i++) begin
            bit term;
            bit apply;
            if (!ch_en[i]) begin
                term      = 1'b0;
                apply     = m_pend[i];
                m_lvl[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_tseg[i] = m_n + 1;
            end else begin
                term  = ((m_n - m_tseg[i]) % (longint'(m_d[i]) + 1)) == longint'(m_d[i]);
                apply = m_pend[i] && term;
                if (apply && (m_smode[i] != m_mode[i])) begin
                    m_lvl[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                end else if (m_mode[i]) begin
                    m_lvl[i]  = 1'b0;
                    m_tick[i] = term;
                end else begin
                    m_lvl[i]  = m_lvl[i] ^ term;
                    m_tick[i] = 1'b0;
                end
                if (apply) m_tseg[i] = m_n + 1;
            end
            if (apply) begin
                m_d[i]    = m_sd[i];
                m_mode[i] = m_smode[i];
                m_pend[i] = 1'b0;
            end else if (acc && (ach == i)) begin
                m_sd[i]    = int'(cfg.cfg_div);
                m_smode[i] = cfg.cfg_mode;
                m_pend[i]  = 1'b1;
            end
        end
        m_half = !m_half;
        m_n++;
    endfunction

    // Model advance; each edge pushes the outputs expected after it.
    always @(posedge clk_in or posedge reset) begin
        exp_t e;
        if (reset) begin
            model_reset();
            exp_q.delete();
        end else begin
            model_step();
        end
        e.clk_out = m_lvl;
        e.tick    = m_tick;
        e.half    = m_half;
        exp_q.push_back(e);
    end

    // Monitor: pop and compare mid-cycle.
    always @(negedge clk_in) begin
        exp_t e;
        bit   exp_rdy;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clk_out",  32'(clk_out),  32'(e.clk_out));
            check("tick",     32'(tick),     32'(e.tick));
            check("clk_half", 32'(clk_half), 32'(e.half));
        end
        exp_rdy = (int'(cfg.cfg_ch) < NUM_CH) ? !m_pend[int'(cfg.cfg_ch)] : 1'b1;
        check("cfg_ready", 32'(cfg.cfg_ready), 32'(exp_rdy));
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_write(input int unsigned ch, input int unsigned d, input bit mode, output int waited);
        bit rdy;
        waited        = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = CH_W'(ch);
        cfg.cfg_div   = CNT_W'(d);
        cfg.cfg_mode  = mode;
        forever begin
            @(negedge clk_in);
            rdy = cfg.cfg_ready;
            @(posedge clk_in);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cfg_accept_timeout ch%0d: waited %0d cycles, required accept within 200", ch, waited);
                break;
            end
        end
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        int          w;
        int unsigned sel;
        int unsigned bit_idx;

        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_div   = '0;
        cfg.cfg_mode  = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b0;
        run(4);

        // Default divisor on both channels.
        ch_en = '1;
        run(24);

        // ch0 to D=1 toggle, then ch1 to D=4 strobe.
        cfg_write(0, 1, MODE_TOGGLE, w);
        run(20);
        cfg_write(1, 4, MODE_STROBE, w);
        run(24);

        // D=0 in both modes on ch0.
        cfg_write(0, 0, MODE_TOGGLE, w);
        run(8);
        cfg_write(0, 0, MODE_STROBE, w);
        run(8);

        // Back-to-back writes: the second must wait for the first to apply.
        cfg_write(0, 2, MODE_TOGGLE, w);
        cfg_write(0, 5, MODE_TOGGLE, w);
        check("b2b_stall", 32'(w > 0), 32'd1);
        run(30);

        // Enable drop and restart mid-period.
        ch_en[0] = 1'b0;
        run(5);
        ch_en[0] = 1'b1;
        run(20);

        // Reset mid-period restores the default divisor on both channels.
        run(3);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(24);

        // Randomized writes, enable flips and idle gaps.
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: cfg_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 6), 1'($urandom_range(0, 1)), w);
                1: begin
                    bit_idx = $urandom_range(0, NUM_CH - 1);
                    ch_en[bit_idx] = ~ch_en[bit_idx];
                end
                default: run(int'($urandom_range(1, 8)));
            endcase
        end

        run(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
